dmem_responder: RTL

//  Memory-side responder for the core's data-memory port; it answers ld/sd requests.

---
 rtl/dmem_responder_if.sv | 25 ++
 rtl/dmem_responder.sv | 118 +++++++++++
 2 files changed

// File: rtl/dmem_responder_if.sv
// Request/response bundle between a load/store requester and the data-memory responder.
// Both directions use valid/ready handshakes; clk and reset stay outside the bundle.
interface dmem_responder_if #(
  parameter int ADDR_W = 10
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [63:0]       req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [63:0]       resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: accepts one 64-bit ld/sd at a time, waits
// WAIT_CYCLES cycles, then holds the response until the requester takes it.
module dmem_responder #(
  parameter int ADDR_W      = 10,
  parameter int DEPTH_BYTES = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input logic             clk,
  input logic             reset,
  dmem_responder_if.slave bus
);
  localparam int DEPTH_WORDS = DEPTH_BYTES / 8;
  localparam int IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt;
  logic              write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [63:0]       wdata_q;
  logic [63:0]       rdata_q;
  logic              err_q;

  // Storage is held as aligned doublewords; byte k of a word is bits [8k+7:8k],
  // which is exactly the little-endian byte view since every legal access is aligned.
  logic [63:0]       mem [DEPTH_WORDS];

  logic              accept;
  logic              enter_resp;
  logic              op_write;
  logic              op_err;
  logic [ADDR_W-1:0] op_addr;
  logic [63:0]       op_wdata;
  logic [ADDR_W:0]   op_last;
  logic [IDX_W-1:0]  op_idx;

  assign accept     = (state == IDLE) && bus.req_valid;
  assign enter_resp = (state != RESP) && (state_nxt == RESP);

  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.req_valid) state_nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT:    if (cnt == 4'd0) state_nxt = RESP;
      RESP:    if (bus.resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // With zero wait states the commit edge is the accept edge, so the operation
  // must come straight from the bus rather than from the latched copy.
  always_comb begin
    op_write = write_q;
    op_addr  = addr_q;
    op_wdata = wdata_q;
    if (state == IDLE) begin
      op_write = bus.req_write;
      op_addr  = bus.req_addr;
      op_wdata = bus.req_wdata;
    end
    op_last = {1'b0, op_addr} + (ADDR_W+1)'(7);
    op_err  = (op_addr[2:0] != 3'd0) || (32'(op_last) >= DEPTH_BYTES);
    op_idx  = IDX_W'(op_addr >> 3);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= 4'd0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        write_q <= bus.req_write;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        cnt     <= (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end

      // Response payload is captured on entry to RESP and zeroed once consumed.
      if (enter_resp) begin
        rdata_q <= (op_write || op_err) ? 64'd0 : mem[op_idx];
        err_q   <= op_err;
      end else if (state == RESP && bus.resp_ready) begin
        rdata_q <= '0;
        err_q   <= 1'b0;
      end
    end
  end

  // NOTE: storage must read back as zero after any reset, so each word sits on the async reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
    end else if (enter_resp && op_write && !op_err) begin
      mem[op_idx] <= op_wdata;
    end
  end

  always_comb begin
    bus.req_ready  = (state == IDLE);
    bus.resp_valid = (state == RESP);
    bus.resp_rdata = rdata_q;
    bus.resp_err   = err_q;
  end
endmodule
